// File: rtl/udp_tx_pkg.sv
// Shared definitions for the UDP transmit port: result codes seen by the
// arbiter, FSM state encoding and UDP header geometry.
package udp_tx_pkg;

  localparam logic [1:0] UDPTX_RESULT_NONE    = 2'b00;
  localparam logic [1:0] UDPTX_RESULT_SENDING = 2'b01;
  localparam logic [1:0] UDPTX_RESULT_SENT    = 2'b11;
  localparam logic [1:0] UDPTX_RESULT_ERR     = 2'b10;

  localparam int HDR_LEN = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_HEADER,
    ST_PAYLOAD,
    ST_ABORT,
    ST_DRAIN,
    ST_RESULT
  } state_e;

endpackage

// File: rtl/udp_tx_port.sv
// UDP transmit responder: answers the arbiter request/status handshake and
// prepends the 8-byte UDP header to the client payload on a byte AXI-stream.
module udp_tx_port
  import udp_tx_pkg::*;
#(
  parameter logic [15:0] SRC_PORT      = 16'd4660,
  parameter int          MAX_LEN       = 1472,
  parameter int          TIMEOUT       = 1024,
  parameter int          RESULT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  output logic [1:0]  status,
  input  logic [15:0] dst_port,
  input  logic [15:0] len,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  output logic        m_tuser,
  input  logic        m_tready
);

  localparam int              IW        = $clog2(TIMEOUT + 1);
  localparam logic [15:0]     MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [IW-1:0]   IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [7:0]      RES_LAST  = 8'(RESULT_CYCLES - 1);
  localparam logic [15:0]     HDR_LEN_W = 16'(HDR_LEN);

  state_e        state_q, state_d;
  logic [15:0]   dst_q, dst_d;
  logic [15:0]   len_q, len_d;
  logic [2:0]    idx_q, idx_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [1:0]    res_q, res_d;
  logic [7:0]    rcnt_q, rcnt_d;

  logic [15:0] udp_len;
  logic        final_beat;

  assign udp_len    = len_q + HDR_LEN_W;
  assign final_beat = (cnt_q == len_q - 16'd1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value; next-state logic lives in always_comb below.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      res_q   <= UDPTX_RESULT_NONE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      res_q   <= res_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // NOTE: every output and next-state variable is defaulted first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d  = state_q;
    dst_d    = dst_q;
    len_d    = len_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    res_d    = res_q;
    rcnt_d   = rcnt_q;
    status   = UDPTX_RESULT_NONE;
    s_tready = 1'b0;
    m_tdata  = 8'h00;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tuser  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          dst_d   = dst_port;
          len_d   = len;
          state_d = ST_START;
        end
      end

      ST_START: begin
        status = UDPTX_RESULT_SENDING;
        idx_d  = '0;
        cnt_d  = '0;
        idle_d = '0;
        rcnt_d = '0;
        if (len_q > MAX_LEN_W) begin
          res_d   = UDPTX_RESULT_ERR;
          state_d = ST_RESULT;
        end else begin
          state_d = ST_HEADER;
        end
      end

      ST_HEADER: begin
        status   = UDPTX_RESULT_SENDING;
        m_tvalid = 1'b1;
        case (idx_q)
          3'd0:    m_tdata = SRC_PORT[15:8];
          3'd1:    m_tdata = SRC_PORT[7:0];
          3'd2:    m_tdata = dst_q[15:8];
          3'd3:    m_tdata = dst_q[7:0];
          3'd4:    m_tdata = udp_len[15:8];
          3'd5:    m_tdata = udp_len[7:0];
          default: m_tdata = 8'h00;
        endcase
        m_tlast = (idx_q == 3'd7) && (len_q == 16'd0);
        if (m_tready) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            if (len_q == 16'd0) begin
              res_d   = UDPTX_RESULT_SENT;
              state_d = ST_RESULT;
            end else begin
              state_d = ST_PAYLOAD;
            end
          end
        end
      end

      ST_PAYLOAD: begin
        status   = UDPTX_RESULT_SENDING;
        s_tready = m_tready;
        m_tdata  = s_tdata;
        m_tvalid = s_tvalid;
        // Early tlast and missing tlast both close the frame flagged as aborted.
        m_tlast  = s_tvalid & (s_tlast | final_beat);
        m_tuser  = s_tvalid & (s_tlast ^ final_beat);
        if (s_tvalid && m_tready) begin
          idle_d = '0;
          cnt_d  = cnt_q + 16'd1;
          if (final_beat && s_tlast) begin
            res_d   = UDPTX_RESULT_SENT;
            state_d = ST_RESULT;
          end else if (final_beat) begin
            state_d = ST_DRAIN;
          end else if (s_tlast) begin
            res_d   = UDPTX_RESULT_ERR;
            state_d = ST_RESULT;
          end
        end else if (!s_tvalid) begin
          idle_d = idle_q + 1'b1;
          if (idle_q == IDLE_LAST) state_d = ST_ABORT;
        end
      end

      ST_ABORT: begin
        status   = UDPTX_RESULT_SENDING;
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tuser  = 1'b1;
        if (m_tready) begin
          res_d   = UDPTX_RESULT_ERR;
          state_d = ST_RESULT;
        end
      end

      ST_DRAIN: begin
        status   = UDPTX_RESULT_SENDING;
        s_tready = 1'b1;
        if (s_tvalid) begin
          idle_d = '0;
          if (s_tlast) begin
            res_d   = UDPTX_RESULT_ERR;
            state_d = ST_RESULT;
          end
        end else begin
          idle_d = idle_q + 1'b1;
          if (idle_q == IDLE_LAST) begin
            res_d   = UDPTX_RESULT_ERR;
            state_d = ST_RESULT;
          end
        end
      end

      ST_RESULT: begin
        status = res_q;
        rcnt_d = rcnt_q + 8'd1;
        if (rcnt_q == RES_LAST) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_udp_tx_port.sv
// Directed bench for udp_tx_port: expected datagram beats are queued by the
// stimulus and checked by an independent output monitor.
module tb_udp_tx_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [1:0]  status;
  logic [15:0] dst_port;
  logic [15:0] len;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tuser;
  logic        m_tready;

  logic rdy_man;
  logic toggle_en;
  logic tog = 1'b1;

  int checks = 0;
  int errors = 0;
  int sready_cycles = 0;

  logic [9:0] sb[$];   // {data, last, user}

  assign m_tready = toggle_en ? tog : rdy_man;

  always #5 clk = ~clk;

  udp_tx_port dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .status   (status),
    .dst_port (dst_port),
    .len      (len),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tuser  (m_tuser),
    .m_tready (m_tready)
  );

  always @(posedge clk) tog <= ~tog;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: a beat is taken on the edge that follows this negedge.
  always @(negedge clk) begin
    if (s_tready) sready_cycles++;
    if (!reset && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m_unexpected: got beat %0h/%0b/%0b expected none", m_tdata, m_tlast, m_tuser);
      end else begin
        check("m_beat", {22'd0, m_tdata, m_tlast, m_tuser}, {22'd0, sb.pop_front()});
      end
    end
  end

  task automatic exp_beat(input logic [7:0] d, input logic l, input logic u);
    sb.push_back({d, l, u});
  endtask

  task automatic exp_header(input logic [15:0] dst, input logic [15:0] ulen, input logic last8);
    exp_beat(8'h12, 0, 0);     exp_beat(8'h34, 0, 0);
    exp_beat(dst[15:8], 0, 0); exp_beat(dst[7:0], 0, 0);
    exp_beat(ulen[15:8], 0, 0); exp_beat(ulen[7:0], 0, 0);
    exp_beat(8'h00, 0, 0);     exp_beat(8'h00, last8, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [15:0] dst, input logic [15:0] l);
    req = 1'b1; dst_port = dst; len = l;
    step();
    req = 1'b0; dst_port = 16'hFFFF; len = 16'hFFFF;
    check("status_sending", {30'd0, status}, 32'h1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n = 0;
    s_tdata = d; s_tvalid = 1'b1; s_tlast = last;
    @(negedge clk);
    while (!s_tready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got s_tready=0 expected 1 for byte %0h", d);
    end
    step();
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00;
  endtask

  task automatic finish_check(input string name, input logic [1:0] res, input int budget);
    int n = 0;
    while (status == 2'b01 && n < budget) begin
      step();
      n++;
    end
    check({name, "_res1"}, {30'd0, status}, {30'd0, res});
    step();
    check({name, "_res2"}, {30'd0, status}, {30'd0, res});
    step();
    check({name, "_none"}, {30'd0, status}, 32'h0);
    step();
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic nominal(input logic [15:0] dst);
    exp_header(dst, 16'h000C, 0);
    exp_beat(8'hAA, 0, 0); exp_beat(8'hBB, 0, 0);
    exp_beat(8'hCC, 0, 0); exp_beat(8'hDD, 1, 0);
    do_req(dst, 16'd4);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    send_byte(8'hCC, 0); send_byte(8'hDD, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    int sr0;
    reset = 1'b1; req = 1'b0; dst_port = '0; len = '0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    rdy_man = 1'b1; toggle_en = 1'b0;
    repeat (3) step();
    check("rst_status", {30'd0, status}, 32'h0);
    check("rst_outs", {27'd0, s_tready, m_tvalid, m_tlast, m_tuser, 1'b0}, 32'h0);
    check("rst_tdata", {24'd0, m_tdata}, 32'h0);
    reset = 1'b0;
    step();

    // Nominal 4-byte packet
    nominal(16'h1234);
    finish_check("nominal", 2'b11, 40);

    // Zero-length payload: header only, payload port never ready
    sr0 = sready_cycles;
    exp_header(16'h0050, 16'h0008, 1);
    do_req(16'h0050, 16'd0);
    finish_check("zero", 2'b11, 40);
    check("zero_no_sready", sready_cycles - sr0, 0);

    // Oversize: one SENDING cycle, then ERR, no output
    do_req(16'h0051, 16'd1500);
    finish_check("oversize", 2'b10, 1);

    // Early tlast on the 2nd of 4 bytes
    exp_header(16'h0052, 16'h000C, 0);
    exp_beat(8'h11, 0, 0); exp_beat(8'h22, 1, 1);
    do_req(16'h0052, 16'd4);
    send_byte(8'h11, 0); send_byte(8'h22, 1);
    finish_check("early", 2'b10, 40);

    // Late tlast: 4 bytes against len=2, last two drained
    exp_header(16'h0053, 16'h000A, 0);
    exp_beat(8'h11, 0, 0); exp_beat(8'h22, 1, 1);
    do_req(16'h0053, 16'd2);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    send_byte(8'h33, 0); send_byte(8'h44, 1);
    finish_check("late", 2'b10, 40);

    // Input idle for TIMEOUT cycles mid-payload: abort beat
    exp_header(16'h0054, 16'h000C, 0);
    exp_beat(8'h11, 0, 0); exp_beat(8'h00, 1, 1);
    do_req(16'h0054, 16'd4);
    send_byte(8'h11, 0);
    finish_check("timeout", 2'b10, 1100);

    // 50% downstream backpressure
    toggle_en = 1'b1;
    nominal(16'hBEEF);
    finish_check("toggle", 2'b11, 40);
    toggle_en = 1'b0;

    // 2000-cycle downstream stall mid-payload must not time out
    exp_header(16'h0055, 16'h000B, 0);
    exp_beat(8'h01, 0, 0); exp_beat(8'h02, 0, 0); exp_beat(8'h03, 1, 0);
    do_req(16'h0055, 16'd3);
    send_byte(8'h01, 0);
    rdy_man = 1'b0;
    fork
      send_byte(8'h02, 0);
      begin
        repeat (2000) step();
        rdy_man = 1'b1;
      end
    join
    send_byte(8'h03, 1);
    finish_check("stall", 2'b11, 40);

    // Reset mid-payload, then a clean packet
    nominal_partial();
    reset = 1'b1;
    step();
    sb.delete();
    check("midrst_status", {30'd0, status}, 32'h0);
    check("midrst_mvalid", {31'd0, m_tvalid}, 32'h0);
    reset = 1'b0;
    step();
    nominal(16'h1234);
    finish_check("post_reset", 2'b11, 40);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic nominal_partial();
    exp_header(16'h0056, 16'h000C, 0);
    exp_beat(8'hAA, 0, 0); exp_beat(8'hBB, 0, 0);
    do_req(16'h0056, 16'd4);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
  endtask

endmodule

// File: doc/udp_tx_port.md
Name: udp_tx_port

Overview:
- Transmit-side responder for the UDP TX port request/status handshake.
- Sits downstream of the UDP port arbiter. It accepts a single-cycle-qualified request, reports NONE/SENDING/SENT/ERR, and prepends an 8-byte UDP header to the granted client's payload stream. It then forwards header plus payload as a byte AXI-stream toward the IP/MAC framer.

Parameters:
- SRC_PORT, 16'd4660, UDP source port written into the header.
- MAX_LEN, 1472, maximum payload bytes accepted.
- TIMEOUT, 1024, input-idle cycles tolerated mid-payload before abort.
- RESULT_CYCLES, 2, cycles the SENT/ERR result is held before returning to NONE.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req  in  1  transmit request (from arbiter req_Y)
- status  out  2  00 NONE, 01 SENDING, 11 SENT, 10 ERR
- dst_port  in  16  destination port, sampled with req
- len  in  16  payload byte count, sampled with req
- s_tdata  in  8  payload byte
- s_tvalid  in  1  payload valid
- s_tlast  in  1  last payload byte
- s_tready  out  1  payload ready
- m_tdata  out  8  UDP datagram byte
- m_tvalid  out  1  output valid
- m_tlast  out  1  last datagram byte
- m_tuser  out  1  abort marker, valid only with m_tlast
- m_tready  in  1  downstream ready

Behaviour:
- Reset values: status=NONE, s_tready=0, m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0, state=IDLE. Reset mid-packet drops the packet immediately.
- IDLE: status NONE. When req=1, latch dst_port and len, then go to START. req is ignored in every other state.
- START (1 cycle): status SENDING.
  - len>MAX_LEN: go to RESULT with ERR; no output beats.
  - Otherwise: go to HEADER.
  - SENDING therefore appears exactly 1 cycle after the req sample in all cases. The arbiter's wait-for-SENDING must never hang.
- HEADER: status SENDING. Emit 8 bytes, big-endian: SRC_PORT, dst_port, len+8 (16-bit), 16'h0000 checksum.
  - A beat advances only on m_tvalid&m_tready.
  - len==0: byte 8 carries m_tlast=1; go to RESULT with SENT.
  - Otherwise: go to PAYLOAD.
- PAYLOAD: s_tready=m_tready (combinational passthrough). m_tdata=s_tdata, m_tvalid=s_tvalid. A 16-bit counter increments on each accepted beat.
  - Final beat (count==len-1) with s_tlast=1: m_tlast=1; go to RESULT with SENT.
  - s_tlast=1 on an earlier beat: forward it with m_tlast=1, m_tuser=1; go to RESULT with ERR.
  - Final beat with s_tlast=0: forward it with m_tlast=1, m_tuser=1; go to DRAIN.
  - Idle counter: resets on each accepted input beat, increments while s_tvalid=0. m_tready stalls are not counted. At TIMEOUT, go to ABORT.
- ABORT: emit one beat m_tdata=0, m_tlast=1, m_tuser=1; then go to RESULT with ERR.
- DRAIN: s_tready=1, m_tvalid=0. Discard input until s_tlast is accepted or the idle counter reaches TIMEOUT; then go to RESULT with ERR.
- RESULT: status SENT or ERR for exactly RESULT_CYCLES cycles, then IDLE with status NONE.
- Length arithmetic: len+8 truncates to 16 bits; it cannot overflow because MAX_LEN≤65527.

Decomposition:
- Package udp_tx_pkg holds:
  - the UDPTX_RESULT_{NONE,SENDING,SENT,ERR} 2-bit constants, shared with the arbiter;
  - the FSM state encoding;
  - the header length constant 8.
- No sub-module needed. The header byte mux is a case on a 3-bit index inside the block.

Test Plan:
- Nominal: req, dst_port=0x1234, len=4, bytes AA BB CC DD with tlast on DD.
  - m stream: 12 34 12 34 00 0C 00 00 AA BB CC DD, tlast on DD, tuser=0.
  - status: 01 from cycle+1, then 11 for 2 cycles, then 00.
- Zero length: len=0 → 8 header bytes (length field 00 08), tlast on byte 8. s_tready never asserted. Result SENT.
- Oversize: len=1500 → SENDING for exactly 1 cycle, then ERR for 2 cycles. No m_tvalid.
- Early tlast: len=4, tlast on 2nd byte → that beat out with tlast=1, tuser=1; ERR.
- Late tlast, then stall:
  - len=2, 4 bytes sent, tlast on 4th → byte 2 out with tlast=1, tuser=1; bytes 3-4 drained; ERR.
  - Separate run: s_tvalid held 0 for 1024 cycles mid-payload → one abort beat (tlast=1, tuser=1); ERR.
- Backpressure and reset:
  - m_tready toggling 50% → no byte lost or duplicated, and no timeout even with a 2000-cycle m_tready stall.
  - reset asserted mid-payload → next cycle status=00, m_tvalid=0; a subsequent nominal packet passes.
